load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_load_align.sv | 35 +++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM encoding, funct3
// size/sign codes, and lane-mask / legality helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_REQ  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Byte-lane mask for an access of 2**size bytes starting at byte offset off.
  function automatic logic [7:0] lsu_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] ones;
    case (size)
      2'd0:    ones = 8'h01;
      2'd1:    ones = 8'h03;
      2'd2:    ones = 8'h0F;
      default: ones = 8'hFF;
    endcase
    return ones << off;
  endfunction

  function automatic logic lsu_f3_illegal(input logic [2:0] f3, input logic wen,
                                          input logic is64);
    return (f3 == 3'b111) ||
           (!is64 && (f3 == F3_D || f3 == F3_WU)) ||
           (wen && f3[2]);
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
    case (size)
      2'd1:    return addr_lo[0];
      2'd2:    return |addr_lo[1:0];
      2'd3:    return |addr_lo[2:0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: shifts a memory word down by the byte offset
// and sign/zero-extends it according to funct3.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  localparam int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [OFF_W-1:0]      off,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    data    = shifted;
    case (funct3)
      F3_B:  data = DATA_WIDTH'($signed(shifted[7:0]));
      F3_H:  data = DATA_WIDTH'($signed(shifted[15:0]));
      // A 32-bit word only needs extending when the datapath is wider than it.
      F3_W:  data = (DATA_WIDTH == 64) ? DATA_WIDTH'($signed(shifted[31:0]))
                                       : DATA_WIDTH'(shifted[31:0]);
      F3_BU: data = DATA_WIDTH'(shifted[7:0]);
      F3_HU: data = DATA_WIDTH'(shifted[15:0]);
      F3_WU: data = DATA_WIDTH'(shifted[31:0]);
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one outstanding aligned, byte-masked access on a
// handshaked memory port. Optional macro LSU_TIMEOUT_EN adds a MEM_WAIT timeout trap.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_wen,
  input  logic [2:0]              i_req_funct3,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  input  logic [4:0]              i_req_rd,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [4:0]              o_rsp_rd,
  output logic                    o_rsp_trap,
  output logic                    o_mem_valid,
  input  logic                    i_mem_ready,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_wen,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  output logic [DATA_WIDTH/8-1:0] o_mem_mask,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

  localparam int MW    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(MW);
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  lsu_state_e state_q, state_d;

  logic                  req_fire;
  logic [OFF_W-1:0]      req_off;
  logic [1:0]            req_size;
  logic                  req_trap;
  logic                  tmo_hit;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [2:0]            funct3_q;
  logic [OFF_W-1:0]      off_q;
  logic [4:0]            rd_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [MW-1:0]         mask_q;
  logic                  trap_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] load_data;

  assign req_fire = i_req_valid && (state_q == ST_IDLE);
  assign req_off  = i_req_addr[OFF_W-1:0];
  assign req_size = i_req_funct3[1:0];
  assign req_trap = lsu_f3_illegal(i_req_funct3, i_req_wen, DATA_WIDTH == 64) ||
                    lsu_misaligned(i_req_addr[2:0], req_size);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    o_req_ready = 1'b0;
    o_mem_valid = 1'b0;
    o_rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (req_fire) state_d = req_trap ? ST_RESP : ST_MEM_REQ;
      end
      ST_MEM_REQ: begin
        o_mem_valid = 1'b1;
        if (i_mem_ready) state_d = ST_MEM_WAIT;
      end
      // rvalid is only looked at here, so one coinciding with the request
      // handshake or arriving stray in IDLE is ignored.
      ST_MEM_WAIT: if (i_mem_rvalid || tmo_hit) state_d = ST_RESP;
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the data registers are reset too, because every output they drive
  // must read zero straight out of reset (these are flops, not a memory array).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q   <= '0;
      wen_q    <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      rd_q     <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      trap_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (req_fire) begin
        addr_q   <= {i_req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        wen_q    <= i_req_wen;
        funct3_q <= i_req_funct3;
        off_q    <= req_off;
        rd_q     <= i_req_wen ? 5'd0 : i_req_rd;
        wdata_q  <= i_req_wen ? (i_req_wdata << {req_off, 3'b000}) : '0;
        mask_q   <= MW'(lsu_mask(req_size, 3'(req_off)));
        trap_q   <= req_trap;
        rdata_q  <= '0;
      end
      if (state_q == ST_MEM_WAIT && i_mem_rvalid && !wen_q) rdata_q <= load_data;
      if (tmo_hit) trap_q <= 1'b1;
    end
  end

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .rdata  (i_mem_rdata),
    .off    (off_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

`ifdef LSU_TIMEOUT_EN
  logic [15:0] tmo_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                  tmo_q <= '0;
    else if (state_q == ST_MEM_REQ && i_mem_ready) tmo_q <= '0;
    else if (state_q == ST_MEM_WAIT)               tmo_q <= tmo_q + 16'd1;
  end

  // Fires on the TIMEOUT_CYCLES-th MEM_WAIT cycle (count runs 0..limit-1).
  assign tmo_hit = (state_q == ST_MEM_WAIT) && !i_mem_rvalid &&
                   (tmo_q == TMO_LIMIT - 16'd1);
`else
  logic unused_tmo_limit;
  assign unused_tmo_limit = ^TMO_LIMIT;
  assign tmo_hit          = 1'b0;
`endif

  assign o_mem_addr  = addr_q;
  assign o_mem_wen   = wen_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_mask  = mask_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_rd    = rd_q;
  assign o_rsp_trap  = trap_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (DATA_WIDTH=32): table-driven
// transactions plus hand sequences for async reset, stray rvalid and timeout.
module tb_load_store_unit;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_req_wen = 1'b0;
  logic [2:0]    i_req_funct3 = '0;
  logic [AW-1:0] i_req_addr = '0;
  logic [DW-1:0] i_req_wdata = '0;
  logic [4:0]    i_req_rd = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b0;
  logic [DW-1:0] o_rsp_rdata;
  logic [4:0]    o_rsp_rd;
  logic          o_rsp_trap;
  logic          o_mem_valid;
  logic          i_mem_ready = 1'b0;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_wen;
  logic [DW-1:0] o_mem_wdata;
  logic [3:0]    o_mem_mask;
  logic          i_mem_rvalid = 1'b0;
  logic [DW-1:0] i_mem_rdata = '0;

  load_store_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
    .i_req_funct3(i_req_funct3), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .i_req_rd(i_req_rd),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_rd(o_rsp_rd), .o_rsp_trap(o_rsp_trap),
    .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
    .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] mrdata;
    int          lat;     // cycles in MEM_WAIT before rvalid (>=1)
    int          rdly;    // cycles i_mem_ready held low
    int          sdly;    // cycles i_rsp_ready held low
    logic        stray;   // rvalid pulsed during the request handshake
    logic        trap;
    logic [31:0] maddr;
    logic [3:0]  mask;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    logic [4:0]  rsp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic wen, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                     input logic [31:0] mrdata, input int lat, input int rdly, input int sdly,
                     input logic stray, input logic trap, input logic [31:0] maddr,
                     input logic [3:0] mask, input logic [31:0] mwdata,
                     input logic [31:0] rdata, input logic [4:0] rsp_rd);
    vec_t v;
    v.name = name; v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.mrdata = mrdata; v.lat = lat; v.rdly = rdly; v.sdly = sdly; v.stray = stray;
    v.trap = trap; v.maddr = maddr; v.mask = mask; v.mwdata = mwdata;
    v.rdata = rdata; v.rsp_rd = rsp_rd;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    int n;
    @(negedge i_clk);
    check({v.name, ".req_ready"}, o_req_ready, 1);
    i_req_valid = 1'b1; i_req_wen = v.wen; i_req_funct3 = v.f3;
    i_req_addr = v.addr; i_req_wdata = v.wdata; i_req_rd = v.rd;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0; i_req_wdata = '1; i_req_addr = '1;
    start = cyc;
    if (v.trap) begin
      check({v.name, ".no_mem_valid"}, o_mem_valid, 0);
    end else begin
      check({v.name, ".mem_valid"}, o_mem_valid, 1);
      check({v.name, ".mem_addr"}, o_mem_addr, v.maddr);
      check({v.name, ".mem_mask"}, o_mem_mask, v.mask);
      check({v.name, ".mem_wen"}, o_mem_wen, v.wen);
      if (v.wen) check({v.name, ".mem_wdata"}, o_mem_wdata, v.mwdata);
      for (int i = 0; i < v.rdly; i++) begin
        @(posedge i_clk); #1;
        check({v.name, ".hold_mem_valid"}, o_mem_valid, 1);
        check({v.name, ".hold_mem_addr"}, o_mem_addr, v.maddr);
        check({v.name, ".hold_mem_mask"}, o_mem_mask, v.mask);
        check({v.name, ".hold_req_ready"}, o_req_ready, 0);
      end
      i_mem_ready = 1'b1;
      if (v.stray) begin
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBAD0_BAD0;
      end
      @(posedge i_clk); #1;
      i_mem_ready = 1'b0; i_mem_rvalid = 1'b0;
      check({v.name, ".mem_valid_drop"}, o_mem_valid, 0);
      if (v.stray) check({v.name, ".stray_ignored"}, o_rsp_valid, 0);
      for (int i = 1; i < v.lat; i++) begin
        @(posedge i_clk); #1;
      end
      i_mem_rvalid = 1'b1; i_mem_rdata = v.mrdata;
      @(posedge i_clk); #1;
      i_mem_rvalid = 1'b0; i_mem_rdata = 32'h5A5A_5A5A;
    end
    n = 0;
    while (!o_rsp_valid && n < 40) begin
      @(posedge i_clk); #1;
      n++;
    end
    check({v.name, ".rsp_valid"}, o_rsp_valid, 1);
    check({v.name, ".latency"}, cyc - start, v.trap ? 0 : v.rdly + 1 + v.lat);
    for (int i = 0; i < v.sdly; i++) begin
      check({v.name, ".hold_rdata"}, o_rsp_rdata, v.rdata);
      check({v.name, ".hold_req_ready"}, o_req_ready, 0);
      @(posedge i_clk); #1;
      check({v.name, ".hold_rsp_valid"}, o_rsp_valid, 1);
    end
    check({v.name, ".rdata"}, o_rsp_rdata, v.rdata);
    check({v.name, ".rd"}, o_rsp_rd, v.rsp_rd);
    check({v.name, ".trap"}, o_rsp_trap, v.trap);
    check({v.name, ".mem_valid_in_resp"}, o_mem_valid, 0);
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
    check({v.name, ".rsp_done"}, o_rsp_valid, 0);
    check({v.name, ".idle_ready"}, o_req_ready, 1);
  endtask

  initial begin
    //   name       wen f3      addr          wdata         rd     mrdata        lat rdly sdly stray trap maddr         mask    mwdata        rdata         rsp_rd
    add("lw",       0, 3'b010, 32'h0000_1004, 32'h0,        5'd5,  32'hDEADBEEF, 3,  0,   0,   0,    0,   32'h0000_1004, 4'b1111, 32'h0,        32'hDEADBEEF, 5'd5);
    add("lb",       0, 3'b000, 32'h0000_2003, 32'h0,        5'd6,  32'h80112233, 1,  0,   0,   1,    0,   32'h0000_2000, 4'b1000, 32'h0,        32'hFFFFFF80, 5'd6);
    add("lbu",      0, 3'b100, 32'h0000_2003, 32'h0,        5'd7,  32'h80112233, 2,  1,   1,   0,    0,   32'h0000_2000, 4'b1000, 32'h0,        32'h00000080, 5'd7);
    add("sh",       1, 3'b001, 32'h0000_3002, 32'h0000ABCD, 5'd9,  32'hFFFFFFFF, 2,  5,   4,   0,    0,   32'h0000_3000, 4'b1100, 32'hABCD0000, 32'h0,        5'd0);
    add("lw_mis",   0, 3'b010, 32'h0000_1001, 32'h0,        5'd8,  32'h0,        1,  0,   0,   0,    1,   32'h0,         4'b0,    32'h0,        32'h0,        5'd8);
    add("f3_111",   0, 3'b111, 32'h0000_1000, 32'h0,        5'd10, 32'h0,        1,  0,   2,   0,    1,   32'h0,         4'b0,    32'h0,        32'h0,        5'd10);
    add("lh",       0, 3'b001, 32'h0000_4002, 32'h0,        5'd11, 32'h80017FFF, 1,  0,   0,   0,    0,   32'h0000_4000, 4'b1100, 32'h0,        32'hFFFF8001, 5'd11);
    add("lhu",      0, 3'b101, 32'h0000_4000, 32'h0,        5'd12, 32'h1234F00F, 4,  2,   0,   0,    0,   32'h0000_4000, 4'b0011, 32'h0,        32'h0000F00F, 5'd12);
    add("sb",       1, 3'b000, 32'h0000_5001, 32'h000000A5, 5'd13, 32'h0,        1,  0,   0,   0,    0,   32'h0000_5000, 4'b0010, 32'h0000A500, 32'h0,        5'd0);
    add("sw",       1, 3'b010, 32'h0000_6000, 32'h12345678, 5'd14, 32'hCAFEF00D, 1,  0,   1,   0,    0,   32'h0000_6000, 4'b1111, 32'h12345678, 32'h0,        5'd0);
    add("lh_mis",   0, 3'b001, 32'h0000_4001, 32'h0,        5'd15, 32'h0,        1,  0,   0,   0,    1,   32'h0,         4'b0,    32'h0,        32'h0,        5'd15);
    add("ld_rv32",  0, 3'b011, 32'h0000_4000, 32'h0,        5'd16, 32'h0,        1,  0,   0,   0,    1,   32'h0,         4'b0,    32'h0,        32'h0,        5'd16);
    add("st_bu",    1, 3'b100, 32'h0000_4000, 32'h11,       5'd17, 32'h0,        1,  0,   0,   0,    1,   32'h0,         4'b0,    32'h0,        32'h0,        5'd0);
    add("sw_mis",   1, 3'b010, 32'h0000_6002, 32'h11,       5'd18, 32'h0,        1,  0,   0,   0,    1,   32'h0,         4'b0,    32'h0,        32'h0,        5'd0);
    add("lb_pos",   0, 3'b000, 32'h0000_7000, 32'h0,        5'd19, 32'h0000007F, 1,  0,   0,   0,    0,   32'h0000_7000, 4'b0001, 32'h0,        32'h0000007F, 5'd19);
    add("lwu_rv32", 0, 3'b110, 32'h0000_7000, 32'h0,        5'd20, 32'h0,        1,  0,   0,   0,    1,   32'h0,         4'b0,    32'h0,        32'h0,        5'd20);

    // Reset values while reset is held.
    #12;
    check("rst.req_ready", o_req_ready, 1);
    check("rst.rsp_valid", o_rsp_valid, 0);
    check("rst.mem_valid", o_mem_valid, 0);
    check("rst.mem_addr",  o_mem_addr, 0);
    check("rst.mem_mask",  o_mem_mask, 0);
    check("rst.mem_wdata", o_mem_wdata, 0);
    check("rst.mem_wen",   o_mem_wen, 0);
    check("rst.rsp_rdata", o_rsp_rdata, 0);
    check("rst.rsp_rd",    o_rsp_rd, 0);
    check("rst.rsp_trap",  o_rsp_trap, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Async reset while waiting for memory: outputs clear before any clock edge.
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_funct3 = 3'b010;
    i_req_addr = 32'h0000_8004; i_req_rd = 5'd21;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_mem_ready = 1'b1;
    @(posedge i_clk); #1;
    i_mem_ready = 1'b0;
    check("arst.in_wait", o_mem_valid, 0);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst.req_ready", o_req_ready, 1);
    check("arst.mem_valid", o_mem_valid, 0);
    check("arst.mem_addr",  o_mem_addr, 0);
    check("arst.mem_mask",  o_mem_mask, 0);
    check("arst.rsp_valid", o_rsp_valid, 0);
    check("arst.rsp_rd",    o_rsp_rd, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // The dropped access's late rvalid arrives in IDLE and must be ignored.
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1234_5678;
    @(posedge i_clk); #1;
    i_mem_rvalid = 1'b0;
    check("stray_idle.rsp_valid", o_rsp_valid, 0);
    check("stray_idle.req_ready", o_req_ready, 1);
    check("stray_idle.rdata",     o_rsp_rdata, 0);

    run_vec(vecs[0]);

`ifdef LSU_TIMEOUT_EN
    begin
      int hs;
      int n;
      @(negedge i_clk);
      i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_funct3 = 3'b010;
      i_req_addr = 32'h0000_9000; i_req_rd = 5'd22;
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      i_mem_ready = 1'b1;
      @(posedge i_clk); #1;
      i_mem_ready = 1'b0;
      hs = cyc;
      n = 0;
      while (!o_rsp_valid && n < 40) begin
        @(posedge i_clk); #1;
        n++;
      end
      check("tmo.rsp_valid", o_rsp_valid, 1);
      check("tmo.latency",   cyc - hs, 4);
      check("tmo.trap",      o_rsp_trap, 1);
      check("tmo.rdata",     o_rsp_rdata, 0);
      i_rsp_ready = 1'b1;
      @(posedge i_clk); #1;
      i_rsp_ready = 1'b0;
      i_mem_rvalid = 1'b1;
      @(posedge i_clk); #1;
      i_mem_rvalid = 1'b0;
      check("tmo.late_rvalid", o_rsp_valid, 0);
      check("tmo.idle_ready",  o_req_ready, 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
